// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - FIFO pointer, occupancy and flag controller for a dual-address register file
module fifo_ctrl #(
  parameter int W      = 2,
  parameter int AF_LVL = 2**W - 1,
  parameter int AE_LVL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr,
  input  logic         rd,
  input  logic         clr,
  output logic         wr_en,
  output logic         re_en,
  output logic [W-1:0] w_addr,
  output logic [W-1:0] r_addr,
  output logic [W:0]   count,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         almost_empty,
  output logic         overflow,
  output logic         underflow
);

  localparam int        D       = 2**W;
  localparam logic [W:0] C_DEPTH = (W+1)'(D);
  localparam logic [W:0] C_AF    = (W+1)'(AF_LVL);
  localparam logic [W:0] C_AE    = (W+1)'(AE_LVL);

  // Threshold sanity: out-of-range levels would make a flag stuck or meaningless
  if (AF_LVL < 1 || AF_LVL > D) begin : g_af_range_err
    $error("fifo_ctrl: AF_LVL must be in 1..2**W");
  end
  if (AE_LVL < 0 || AE_LVL > D - 1) begin : g_ae_range_err
    $error("fifo_ctrl: AE_LVL must be in 0..2**W-1");
  end

  logic [W-1:0] r_wptr;
  logic [W-1:0] r_rptr;
  logic [W:0]   r_count;
  logic         r_full;
  logic         r_empty;
  logic         r_af;
  logic         r_ae;
  logic         r_ovf;
  logic         r_udf;

  logic         w_push;
  logic         w_pop;
  logic [W:0]   w_count_nxt;

  // Full blocks writes and empty blocks reads even when the opposite request is
  // present, so a write never lands on the slot being read in the same cycle
  assign w_push = wr & ~r_full  & ~clr;
  assign w_pop  = rd & ~r_empty & ~clr;

  assign wr_en        = w_push;
  assign re_en        = w_pop;
  assign w_addr       = r_wptr;
  assign r_addr       = r_rptr;
  assign count        = r_count;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

  // Next occupancy: flush wins, otherwise +1/-1 for a lone push/pop
  always_comb begin
    w_count_nxt = r_count;
    if (clr) begin
      w_count_nxt = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + (W+1)'(1);
        2'b01:   w_count_nxt = r_count - (W+1)'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Pointer, count and flag registers; flags decode the next count so they line up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_af    <= 1'b0;
      r_ae    <= 1'b1;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == C_DEPTH);
      r_empty <= (w_count_nxt == '0);
      r_af    <= (w_count_nxt >= C_AF);
      r_ae    <= (w_count_nxt <= C_AE);
      if (clr) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_ovf  <= 1'b0;
        r_udf  <= 1'b0;
      end else begin
        if (w_push)       r_wptr <= r_wptr + W'(1);
        if (w_pop)        r_rptr <= r_rptr + W'(1);
        if (wr & r_full)  r_ovf  <= 1'b1;
        if (rd & r_empty) r_udf  <= 1'b1;
      end
    end
  end

endmodule
